// File: rtl/SchedulerTypes.sv
`default_nettype none
// ============================================================================
//  Package     : SchedulerTypes
//  Description : Shared scheduler widths, issue-queue types and index helpers.
//  Revision    : 1.0
// ============================================================================
package SchedulerTypes;

    localparam int ISSUE_QUEUE_ENTRY_NUM           = 16;
    localparam int RENAME_WIDTH                    = 2;
    localparam int ISSUE_WIDTH                     = 2;
    localparam int ISSUE_QUEUE_RETURN_INDEX_WIDTH  = 2;
    localparam int ISSUE_QUEUE_INDEX_BIT_WIDTH     = $clog2(ISSUE_QUEUE_ENTRY_NUM);
    localparam int ISSUE_QUEUE_COUNT_BIT_WIDTH     = $clog2(ISSUE_QUEUE_ENTRY_NUM + 1);
    localparam int ISSUE_QUEUE_RESET_CYCLE         =
        (ISSUE_QUEUE_ENTRY_NUM + ISSUE_WIDTH + ISSUE_QUEUE_RETURN_INDEX_WIDTH - 1) /
        (ISSUE_WIDTH + ISSUE_QUEUE_RETURN_INDEX_WIDTH);

    typedef logic [ISSUE_QUEUE_INDEX_BIT_WIDTH-1:0] IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_COUNT_BIT_WIDTH-1:0] IssueQueueCountPath;

    typedef enum logic [0:0] {
        IQ_ALLOC_PHASE_INIT = 1'b0,
        IQ_ALLOC_PHASE_RUN  = 1'b1
    } IssueQueueAllocPhase;

    // Single conditional subtraction keeps non-power-of-two depths cheap.
    function automatic int wrapIndex(input int base, input int offset, input int entryNum);
        int sum;
        sum = base + offset;
        if (sum >= entryNum) begin
            sum = sum - entryNum;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_index_allocator_if.sv
`default_nettype none
// ============================================================================
//  Interface   : issue_queue_index_allocator_if
//  Description : Dispatch allocation, issue release and flush return lanes.
//  Revision    : 1.0
// ============================================================================
interface issue_queue_index_allocator_if
    import SchedulerTypes::*;
#(
    parameter int ALLOC_WIDTH   = RENAME_WIDTH,
    parameter int RELEASE_WIDTH = ISSUE_WIDTH,
    parameter int RETURN_WIDTH  = ISSUE_QUEUE_RETURN_INDEX_WIDTH
) ();

    logic [ALLOC_WIDTH-1:0]   allocReq;
    IssueQueueIndexPath       allocPtr [ALLOC_WIDTH];
    logic                     allocatable;
    logic [RELEASE_WIDTH-1:0] releaseValid;
    IssueQueueIndexPath       releasePtr [RELEASE_WIDTH];
    logic [RETURN_WIDTH-1:0]  returnValid;
    IssueQueueIndexPath       returnPtr [RETURN_WIDTH];
    IssueQueueCountPath       freeCount;
    logic                     ready;

    modport master (
        output allocReq, releaseValid, releasePtr, returnValid, returnPtr,
        input  allocPtr, allocatable, freeCount, ready
    );

    modport slave (
        input  allocReq, releaseValid, releasePtr, returnValid, returnPtr,
        output allocPtr, allocatable, freeCount, ready
    );

endinterface
`default_nettype wire

// File: rtl/issue_queue_index_push_compactor.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue_index_push_compactor
//  Description : Packs valid push lanes to the front and counts them.
//  Revision    : 1.0
// ============================================================================
module issue_queue_index_push_compactor
    import SchedulerTypes::*;
#(
    parameter int LANE_NUM = 4
) (
    input  wire logic [LANE_NUM-1:0]          i_valid,
    input  wire IssueQueueIndexPath           i_ptr [LANE_NUM],
    output IssueQueueIndexPath                o_data [LANE_NUM],
    output logic [$clog2(LANE_NUM+1)-1:0]     o_count
);

    localparam int c_COUNT_WIDTH = $clog2(LANE_NUM + 1);

    int w_fill;

    always_comb begin
        w_fill = 0;
        for (int k = 0; k < LANE_NUM; k++) begin
            o_data[k] = '0;
        end
        for (int j = 0; j < LANE_NUM; j++) begin
            if (i_valid[j]) begin
                for (int k = 0; k < LANE_NUM; k++) begin
                    if (k == w_fill) begin
                        o_data[k] = i_ptr[j];
                    end
                end
                w_fill = w_fill + 1;
            end
        end
        o_count = c_COUNT_WIDTH'(w_fill);
    end

endmodule
`default_nettype wire

// File: rtl/issue_queue_index_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue_index_allocator
//  Description : Circular free list of issue-queue indices, self-filled at reset.
//  Revision    : 1.0
// ============================================================================
module issue_queue_index_allocator
    import SchedulerTypes::*;
#(
    parameter int ENTRY_NUM     = ISSUE_QUEUE_ENTRY_NUM,
    parameter int ALLOC_WIDTH   = RENAME_WIDTH,
    parameter int RELEASE_WIDTH = ISSUE_WIDTH,
    parameter int RETURN_WIDTH  = ISSUE_QUEUE_RETURN_INDEX_WIDTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    issue_queue_index_allocator_if.slave  iq
);

    localparam int c_PUSH_WIDTH     = RELEASE_WIDTH + RETURN_WIDTH;
    localparam int c_INIT_CYCLES    = (ENTRY_NUM + c_PUSH_WIDTH - 1) / c_PUSH_WIDTH;
    localparam int c_INIT_CNT_WIDTH = $clog2(c_INIT_CYCLES + 1);
    localparam int c_PUSH_CNT_WIDTH = $clog2(c_PUSH_WIDTH + 1);

    IssueQueueAllocPhase          r_phase;
    IssueQueueAllocPhase          w_phaseNext;
    logic [c_INIT_CNT_WIDTH-1:0]  r_initCycle;
    logic [c_INIT_CNT_WIDTH-1:0]  w_initCycleNext;
    IssueQueueIndexPath           r_head;
    IssueQueueIndexPath           w_headNext;
    IssueQueueIndexPath           r_tail;
    IssueQueueIndexPath           w_tailNext;
    IssueQueueCountPath           r_freeCount;
    IssueQueueCountPath           w_freeCountNext;
    IssueQueueIndexPath           r_entry [ENTRY_NUM];

    logic [c_PUSH_WIDTH-1:0]      w_pushLaneValid;
    IssueQueueIndexPath           w_pushLanePtr [c_PUSH_WIDTH];
    IssueQueueIndexPath           w_compactData [c_PUSH_WIDTH];
    logic [c_PUSH_CNT_WIDTH-1:0]  w_compactCount;
    IssueQueueIndexPath           w_writeData [c_PUSH_WIDTH];
    IssueQueueIndexPath           w_writeIdx [c_PUSH_WIDTH];
    IssueQueueIndexPath           w_allocIdx [ALLOC_WIDTH];
    int                           w_writeCount;
    int                           w_popCount;
    logic                         w_ready;
    logic                         w_allocatable;

    // Release lanes take priority order over return lanes.
    generate
        for (genvar i = 0; i < RELEASE_WIDTH; i++) begin : g_releaseLane
            assign w_pushLaneValid[i] = iq.releaseValid[i];
            assign w_pushLanePtr[i]   = iq.releasePtr[i];
        end
        for (genvar i = 0; i < RETURN_WIDTH; i++) begin : g_returnLane
            assign w_pushLaneValid[RELEASE_WIDTH + i] = iq.returnValid[i];
            assign w_pushLanePtr[RELEASE_WIDTH + i]   = iq.returnPtr[i];
        end
        for (genvar k = 0; k < c_PUSH_WIDTH; k++) begin : g_writeIdx
            assign w_writeIdx[k] = IssueQueueIndexPath'(wrapIndex(int'(r_tail), k, ENTRY_NUM));
        end
        for (genvar i = 0; i < ALLOC_WIDTH; i++) begin : g_allocLane
            assign w_allocIdx[i]  = IssueQueueIndexPath'(wrapIndex(int'(r_head), i, ENTRY_NUM));
            assign iq.allocPtr[i] = w_ready ? r_entry[w_allocIdx[i]] : '0;
        end
    endgenerate

    issue_queue_index_push_compactor #(
        .LANE_NUM (c_PUSH_WIDTH)
    ) u_pushCompactor (
        .i_valid (w_pushLaneValid),
        .i_ptr   (w_pushLanePtr),
        .o_data  (w_compactData),
        .o_count (w_compactCount)
    );

    always_comb begin
        w_ready         = (r_phase == IQ_ALLOC_PHASE_RUN);
        w_allocatable   = w_ready && (int'(r_freeCount) >= ALLOC_WIDTH);
        w_popCount      = 0;
        w_writeCount    = 0;
        w_phaseNext     = r_phase;
        w_initCycleNext = r_initCycle;
        for (int k = 0; k < c_PUSH_WIDTH; k++) begin
            w_writeData[k] = '0;
        end

        if (w_allocatable) begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                w_popCount = w_popCount + (iq.allocReq[i] ? 1 : 0);
            end
        end

        if (r_phase == IQ_ALLOC_PHASE_INIT) begin
            // Seed the free list with ascending indices, W per cycle.
            for (int k = 0; k < c_PUSH_WIDTH; k++) begin
                if (int'(r_initCycle) * c_PUSH_WIDTH + k < ENTRY_NUM) begin
                    w_writeData[k] = IssueQueueIndexPath'(int'(r_initCycle) * c_PUSH_WIDTH + k);
                    w_writeCount   = w_writeCount + 1;
                end
            end
            w_initCycleNext = r_initCycle + c_INIT_CNT_WIDTH'(1);
            if (int'(r_initCycle) == c_INIT_CYCLES - 1) begin
                w_phaseNext     = IQ_ALLOC_PHASE_RUN;
                w_initCycleNext = '0;
            end
        end else begin
            for (int k = 0; k < c_PUSH_WIDTH; k++) begin
                w_writeData[k] = w_compactData[k];
            end
            w_writeCount = int'(w_compactCount);
        end

        w_headNext      = IssueQueueIndexPath'(wrapIndex(int'(r_head), w_popCount, ENTRY_NUM));
        w_tailNext      = IssueQueueIndexPath'(wrapIndex(int'(r_tail), w_writeCount, ENTRY_NUM));
        w_freeCountNext = IssueQueueCountPath'(int'(r_freeCount) - w_popCount + w_writeCount);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase     <= IQ_ALLOC_PHASE_INIT;
            r_initCycle <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_freeCount <= '0;
        end else begin
            r_phase     <= w_phaseNext;
            r_initCycle <= w_initCycleNext;
            r_head      <= w_headNext;
            r_tail      <= w_tailNext;
            r_freeCount <= w_freeCountNext;
        end
    end

    // Storage is intentionally left unreset; INIT rewrites every slot.
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_PUSH_WIDTH; k++) begin
            if (rst_n && (k < w_writeCount)) begin
                r_entry[w_writeIdx[k]] <= w_writeData[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && (r_phase == IQ_ALLOC_PHASE_RUN)) begin
            assert (int'(r_freeCount) - w_popCount + w_writeCount <= ENTRY_NUM);
        end
    end

    assign iq.ready       = w_ready;
    assign iq.allocatable = w_allocatable;
    assign iq.freeCount   = r_freeCount;

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_index_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_queue_index_allocator
//  Description : Scenario tasks plus randomized traffic against a free-list queue.
//  Revision    : 1.0
// ============================================================================
module tb_issue_queue_index_allocator;
    import SchedulerTypes::*;

    localparam int c_ENTRY_NUM     = 16;
    localparam int c_ALLOC_WIDTH   = 2;
    localparam int c_RELEASE_WIDTH = 2;
    localparam int c_RETURN_WIDTH  = 2;
    localparam int c_PUSH_WIDTH    = c_RELEASE_WIDTH + c_RETURN_WIDTH;
    localparam int c_INIT_CYCLES   = (c_ENTRY_NUM + c_PUSH_WIDTH - 1) / c_PUSH_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   model[$];
    int   outstanding[$];
    int   modelInitLeft = c_INIT_CYCLES;

    issue_queue_index_allocator_if #(
        .ALLOC_WIDTH   (c_ALLOC_WIDTH),
        .RELEASE_WIDTH (c_RELEASE_WIDTH),
        .RETURN_WIDTH  (c_RETURN_WIDTH)
    ) iq ();

    issue_queue_index_allocator #(
        .ENTRY_NUM     (c_ENTRY_NUM),
        .ALLOC_WIDTH   (c_ALLOC_WIDTH),
        .RELEASE_WIDTH (c_RELEASE_WIDTH),
        .RETURN_WIDTH  (c_RETURN_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (iq)
    );

    always #5 clk = ~clk;

    task automatic idleInputs();
        iq.allocReq     = '0;
        iq.releaseValid = '0;
        iq.returnValid  = '0;
        for (int i = 0; i < c_RELEASE_WIDTH; i++) iq.releasePtr[i] = '0;
        for (int i = 0; i < c_RETURN_WIDTH; i++)  iq.returnPtr[i]  = '0;
    endtask

    // Advances the free-list model with the inputs currently driven, then clocks.
    task automatic cycle();
        if (!rst_n) begin
            model.delete();
            outstanding.delete();
            modelInitLeft = c_INIT_CYCLES;
        end else if (modelInitLeft > 0) begin
            modelInitLeft--;
            if (modelInitLeft == 0)
                for (int v = 0; v < c_ENTRY_NUM; v++) model.push_back(v);
        end else begin
            if (model.size() >= c_ALLOC_WIDTH)
                for (int i = 0; i < c_ALLOC_WIDTH; i++)
                    if (iq.allocReq[i]) outstanding.push_back(model.pop_front());
            for (int i = 0; i < c_RELEASE_WIDTH; i++)
                if (iq.releaseValid[i]) model.push_back(int'(iq.releasePtr[i]));
            for (int i = 0; i < c_RETURN_WIDTH; i++)
                if (iq.returnValid[i]) model.push_back(int'(iq.returnPtr[i]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idleInputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        nCompared++;
        if (iq.ready !== 1'b0) begin nMismatched++; $display("FAIL reset_ready: got %b want 0", iq.ready); end
        nCompared++;
        if (iq.allocatable !== 1'b0) begin nMismatched++; $display("FAIL reset_allocatable: got %b want 0", iq.allocatable); end
        nCompared++;
        if (iq.freeCount !== '0) begin nMismatched++; $display("FAIL reset_freeCount: got %0d want 0", iq.freeCount); end
        nCompared++;
        if (iq.allocPtr[0] !== '0 || iq.allocPtr[1] !== '0) begin
            nMismatched++; $display("FAIL reset_allocPtr: got %0d,%0d want 0,0", iq.allocPtr[0], iq.allocPtr[1]);
        end
    endtask

    task automatic test_init();
        int expFill;
        rst_n = 1'b1;
        for (int k = 0; k < c_INIT_CYCLES; k++) begin
            // Traffic during INIT must be ignored.
            iq.allocReq     = 2'b11;
            iq.releaseValid = 2'b11;
            iq.returnValid  = 2'b11;
            iq.releasePtr[0] = 4'd13; iq.releasePtr[1] = 4'd2;
            iq.returnPtr[0]  = 4'd7;  iq.returnPtr[1]  = 4'd11;
            nCompared++;
            if (iq.ready !== 1'b0) begin nMismatched++; $display("FAIL init_ready_early: cycle %0d got %b want 0", k, iq.ready); end
            nCompared++;
            if (iq.allocPtr[0] !== '0 || iq.allocPtr[1] !== '0) begin
                nMismatched++; $display("FAIL init_allocPtr: cycle %0d got %0d,%0d want 0,0", k, iq.allocPtr[0], iq.allocPtr[1]);
            end
            cycle();
            expFill = (k + 1) * c_PUSH_WIDTH;
            if (expFill > c_ENTRY_NUM) expFill = c_ENTRY_NUM;
            nCompared++;
            if (int'(iq.freeCount) !== expFill) begin
                nMismatched++; $display("FAIL init_fill: cycle %0d got %0d want %0d", k, iq.freeCount, expFill);
            end
        end
        idleInputs();
        nCompared++;
        if (iq.ready !== 1'b1) begin nMismatched++; $display("FAIL init_ready: got %b want 1", iq.ready); end
        nCompared++;
        if (iq.allocPtr[0] !== 4'd0 || iq.allocPtr[1] !== 4'd1) begin
            nMismatched++; $display("FAIL init_allocPtr_run: got %0d,%0d want 0,1", iq.allocPtr[0], iq.allocPtr[1]);
        end
    endtask

    task automatic test_drain();
        for (int k = 0; k < c_ENTRY_NUM / c_ALLOC_WIDTH; k++) begin
            iq.allocReq = 2'b11;
            nCompared++;
            if (int'(iq.allocPtr[0]) !== 2 * k || int'(iq.allocPtr[1]) !== 2 * k + 1) begin
                nMismatched++; $display("FAIL drain_grant: step %0d got %0d,%0d want %0d,%0d",
                                        k, iq.allocPtr[0], iq.allocPtr[1], 2 * k, 2 * k + 1);
            end
            cycle();
        end
        idleInputs();
        nCompared++;
        if (iq.freeCount !== '0) begin nMismatched++; $display("FAIL drain_freeCount: got %0d want 0", iq.freeCount); end
        nCompared++;
        if (iq.allocatable !== 1'b0) begin nMismatched++; $display("FAIL drain_allocatable: got %b want 0", iq.allocatable); end
    endtask

    task automatic test_push_compaction();
        iq.releaseValid  = 2'b10;
        iq.releasePtr[0] = 4'd12;
        iq.releasePtr[1] = 4'd5;
        iq.returnValid   = 2'b11;
        iq.returnPtr[0]  = 4'd9;
        iq.returnPtr[1]  = 4'd3;
        cycle();
        idleInputs();
        nCompared++;
        if (iq.freeCount !== 5'd3) begin nMismatched++; $display("FAIL compact_freeCount: got %0d want 3", iq.freeCount); end
        nCompared++;
        if (iq.allocPtr[0] !== 4'd5 || iq.allocPtr[1] !== 4'd9) begin
            nMismatched++; $display("FAIL compact_order: got %0d,%0d want 5,9", iq.allocPtr[0], iq.allocPtr[1]);
        end
        nCompared++;
        if (iq.allocatable !== 1'b1) begin nMismatched++; $display("FAIL compact_allocatable: got %b want 1", iq.allocatable); end
        iq.allocReq = 2'b11;
        cycle();
        idleInputs();
        nCompared++;
        if (iq.allocPtr[0] !== 4'd3 || iq.freeCount !== 5'd1) begin
            nMismatched++; $display("FAIL compact_tail: got ptr %0d cnt %0d want ptr 3 cnt 1", iq.allocPtr[0], iq.freeCount);
        end
    endtask

    task automatic test_insufficient();
        nCompared++;
        if (iq.allocatable !== 1'b0) begin nMismatched++; $display("FAIL short_allocatable: got %b want 0", iq.allocatable); end
        iq.allocReq = 2'b01;
        cycle();
        idleInputs();
        nCompared++;
        if (iq.freeCount !== 5'd1 || iq.allocPtr[0] !== 4'd3) begin
            nMismatched++; $display("FAIL short_ignored: got cnt %0d ptr %0d want cnt 1 ptr 3", iq.freeCount, iq.allocPtr[0]);
        end
    endtask

    task automatic test_mid_reset();
        iq.releaseValid = 2'b11; iq.releasePtr[0] = 4'd0; iq.releasePtr[1] = 4'd1;
        iq.returnValid  = 2'b11; iq.returnPtr[0]  = 4'd2; iq.returnPtr[1]  = 4'd4;
        cycle();
        idleInputs();
        iq.releaseValid = 2'b11; iq.releasePtr[0] = 4'd6; iq.releasePtr[1] = 4'd7;
        cycle();
        idleInputs();
        nCompared++;
        if (iq.freeCount !== 5'd7) begin nMismatched++; $display("FAIL midrst_pre_count: got %0d want 7", iq.freeCount); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        nCompared++;
        if (iq.ready !== 1'b0 || iq.freeCount !== '0 || iq.allocatable !== 1'b0) begin
            nMismatched++; $display("FAIL midrst_state: got ready %b cnt %0d alloc %b want 0 0 0",
                                    iq.ready, iq.freeCount, iq.allocatable);
        end
        for (int k = 0; k < c_INIT_CYCLES; k++) cycle();
        nCompared++;
        if (iq.ready !== 1'b1 || int'(iq.freeCount) !== c_ENTRY_NUM) begin
            nMismatched++; $display("FAIL midrst_reinit: got ready %b cnt %0d want 1 %0d", iq.ready, iq.freeCount, c_ENTRY_NUM);
        end
        for (int k = 0; k < c_ENTRY_NUM / c_ALLOC_WIDTH; k++) begin
            iq.allocReq = 2'b11;
            nCompared++;
            if (int'(iq.allocPtr[0]) !== 2 * k || int'(iq.allocPtr[1]) !== 2 * k + 1) begin
                nMismatched++; $display("FAIL midrst_grant: step %0d got %0d,%0d want %0d,%0d",
                                        k, iq.allocPtr[0], iq.allocPtr[1], 2 * k, 2 * k + 1);
            end
            cycle();
        end
        idleInputs();
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < c_INIT_CYCLES; k++) cycle();
        for (int k = 0; k < 7; k++) begin
            iq.allocReq = 2'b11;
            cycle();
        end
        idleInputs();
        nCompared++;
        if (iq.freeCount !== 5'd2 || iq.allocPtr[0] !== 4'd14 || iq.allocPtr[1] !== 4'd15) begin
            nMismatched++; $display("FAIL wrap_setup: got cnt %0d ptr %0d,%0d want 2 14,15", iq.freeCount, iq.allocPtr[0], iq.allocPtr[1]);
        end
        iq.allocReq = 2'b01; iq.releaseValid = 2'b01; iq.releasePtr[0] = 4'd0;
        cycle();
        idleInputs();
        nCompared++;
        if (iq.freeCount !== 5'd2 || iq.allocPtr[0] !== 4'd15 || iq.allocPtr[1] !== 4'd0) begin
            nMismatched++; $display("FAIL wrap_head15: got cnt %0d ptr %0d,%0d want 2 15,0", iq.freeCount, iq.allocPtr[0], iq.allocPtr[1]);
        end
        iq.allocReq = 2'b11; iq.returnValid = 2'b11; iq.returnPtr[0] = 4'd3; iq.returnPtr[1] = 4'd7;
        cycle();
        idleInputs();
        nCompared++;
        if (iq.freeCount !== 5'd2 || iq.allocPtr[0] !== 4'd3 || iq.allocPtr[1] !== 4'd7) begin
            nMismatched++; $display("FAIL wrap_popush: got cnt %0d ptr %0d,%0d want 2 3,7", iq.freeCount, iq.allocPtr[0], iq.allocPtr[1]);
        end
    endtask

    task automatic test_random();
        int sel;
        int pick;
        logic running;
        rst_n = 1'b0;
        idleInputs();
        cycle();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            running = rst_n && (modelInitLeft == 0);
            sel = $urandom_range(0, 2);
            iq.allocReq = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            for (int i = 0; i < c_PUSH_WIDTH; i++) begin
                logic v;
                IssueQueueIndexPath p;
                v = 1'b0;
                p = IssueQueueIndexPath'($urandom_range(0, c_ENTRY_NUM - 1));
                if (!running) begin
                    v = 1'($urandom_range(0, 1));
                end else if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
                    pick = $urandom_range(0, outstanding.size() - 1);
                    p = IssueQueueIndexPath'(outstanding[pick]);
                    outstanding.delete(pick);
                    v = 1'b1;
                end
                if (i < c_RELEASE_WIDTH) begin
                    iq.releaseValid[i] = v; iq.releasePtr[i] = p;
                end else begin
                    iq.returnValid[i - c_RELEASE_WIDTH] = v; iq.returnPtr[i - c_RELEASE_WIDTH] = p;
                end
            end
            cycle();
            nCompared++;
            if (iq.ready !== (modelInitLeft == 0)) begin
                nMismatched++; $display("FAIL rand_ready: iter %0d got %b want %b", n, iq.ready, modelInitLeft == 0);
            end
            if (modelInitLeft == 0) begin
                nCompared++;
                if (int'(iq.freeCount) !== model.size()) begin
                    nMismatched++; $display("FAIL rand_freeCount: iter %0d got %0d want %0d", n, iq.freeCount, model.size());
                end
                nCompared++;
                if (iq.allocatable !== (model.size() >= c_ALLOC_WIDTH)) begin
                    nMismatched++; $display("FAIL rand_allocatable: iter %0d got %b want %b", n, iq.allocatable, model.size() >= c_ALLOC_WIDTH);
                end
                for (int i = 0; i < c_ALLOC_WIDTH; i++) begin
                    if (i < model.size()) begin
                        nCompared++;
                        if (int'(iq.allocPtr[i]) !== model[i]) begin
                            nMismatched++; $display("FAIL rand_allocPtr: iter %0d lane %0d got %0d want %0d", n, i, iq.allocPtr[i], model[i]);
                        end
                    end
                end
            end else begin
                nCompared++;
                if (iq.allocPtr[0] !== '0 || iq.allocPtr[1] !== '0) begin
                    nMismatched++; $display("FAIL rand_init_allocPtr: iter %0d got %0d,%0d want 0,0", n, iq.allocPtr[0], iq.allocPtr[1]);
                end
            end
        end
        idleInputs();
        rst_n = 1'b1;
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_init();
        test_drain();
        test_push_compaction();
        test_insufficient();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_queue_index_allocator.md
ISSUE_QUEUE_INDEX_ALLOCATOR -- requirements
Module: issue_queue_index_allocator

Interface
REQ-001 Parameter ENTRY_NUM, default ISSUE_QUEUE_ENTRY_NUM: number of issue-queue entries managed.
REQ-002 Parameter ALLOC_WIDTH, default RENAME_WIDTH: dispatch allocation lanes per cycle.
REQ-003 Parameter RELEASE_WIDTH, default ISSUE_WIDTH: issue-time release lanes per cycle.
REQ-004 Parameter RETURN_WIDTH, default ISSUE_QUEUE_RETURN_INDEX_WIDTH: flush-return lanes per cycle.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 allocReq  input  ALLOC_WIDTH  per-lane dispatch request.
REQ-008 allocPtr  output  ALLOC_WIDTH x IssueQueueIndexPath  index granted per lane.
REQ-009 allocatable  output  1  freeCount >= ALLOC_WIDTH and ready.
REQ-010 releaseValid/releasePtr  input  RELEASE_WIDTH x (1 + IssueQueueIndexPath)  indices freed at issue.
REQ-011 returnValid/returnPtr  input  RETURN_WIDTH x (1 + IssueQueueIndexPath)  indices freed by flush walk.
REQ-012 freeCount  output  IssueQueueCountPath  registered free-entry count.
REQ-013 ready  output  1  high only in RUN phase.

Function
REQ-014 Storage: circular FIFO of ENTRY_NUM indices; head (pop), tail (push) wrap modulo ENTRY_NUM by conditional subtraction; ENTRY_NUM need not be a power of two.
REQ-015 Phases: INIT, RUN; reset enters INIT with head=0, tail=0, freeCount=0, initCycle=0.
REQ-016 INIT: each cycle writes indices initCycle*W+k (W=RELEASE_WIDTH+RETURN_WIDTH, k<W, only values <ENTRY_NUM) at tail+k; tail and freeCount advance by number written.
REQ-017 INIT -> RUN after the cycle with initCycle == ISSUE_QUEUE_RESET_CYCLE-1; INIT lasts exactly ceil(ENTRY_NUM/W) cycles.
REQ-018 In INIT all alloc/release/return inputs are ignored; allocPtr driven 0.
REQ-019 allocPtr[i] = entry[head+i mod ENTRY_NUM], combinational from registered state.
REQ-020 allocReq must be lane-contiguous from lane 0; pops = popcount(allocReq), taken only when allocatable=1; otherwise requests ignored, state unchanged.
REQ-021 Push lanes ordered release[0..] then return[0..]; valid lanes compacted and written at tail, tail+1, ...; invalid lanes leave no gap.
REQ-022 freeCount_next = freeCount - pops + pushes; pop and push in same cycle both take effect.
REQ-023 allocatable derived from registered freeCount only; pushed indices grantable no earlier than next cycle.
REQ-024 Push exceeding ENTRY_NUM capacity is illegal; simulation assertion fires; behaviour undefined.
REQ-025 Duplicate index push is not checked by this block.

Reset
REQ-026 rst_n=0 at any clock edge, including mid-INIT or mid-RUN, discards contents and re-enters INIT per REQ-015.
REQ-027 Reset values: ready=0, allocatable=0, freeCount=0, allocPtr=0; storage array not reset.

Structure
REQ-028 SchedulerTypes package holds IssueQueueIndexPath, IssueQueueCountPath, ISSUE_QUEUE_RETURN_INDEX_WIDTH, ISSUE_QUEUE_RESET_CYCLE and a new enum IssueQueueAllocPhase {IQ_ALLOC_PHASE_INIT, IQ_ALLOC_PHASE_RUN}.
REQ-029 One sub-module issue_queue_index_push_compactor: valid-lane compaction producing packed write data and push count.

Verification (ENTRY_NUM=16, ALLOC=2, RELEASE=2, RETURN=2, W=4)
REQ-030 Release reset -> ready rises after exactly 4 cycles; freeCount=16; allocPtr={0,1}.
REQ-031 allocReq=2'b11 for 8 cycles -> grants 0..15 in order; freeCount=0; allocatable=0.
REQ-032 From empty: release {lane0 invalid, lane1 ptr 5}, return {9, 3} -> next cycle freeCount=3, allocPtr={5,9}, then 3.
REQ-033 freeCount=2 with head=15: alloc 2 and push 2 same cycle -> freeCount stays 2; head/tail wrap 15->0 correctly.
REQ-034 freeCount=1, allocReq=2'b01 -> ignored (allocatable=0); freeCount stays 1.
REQ-035 rst_n low one cycle in RUN with freeCount=7 -> ready=0, freeCount=0; re-INIT yields indices 0..15.
